// File: rtl/fc_pkg.sv
// Shared state type, default widths and the accumulator-width rule for the FC layer engine.
package fc_pkg;

  localparam int FC_N_IN   = 3136;
  localparam int FC_N_OUT  = 10;
  localparam int FC_IN_W   = 30;
  localparam int FC_WT_W   = 9;
  localparam int FC_B_W    = 9;
  localparam int FC_ACC_W  = 52;
  localparam int FC_OUT_W  = 38;

  typedef enum logic [2:0] {IDLE, LOAD, MAC, SAT, EMIT, FIN} state_t;

  // The sum of N_IN full-width products must never wrap the accumulator.
  function automatic bit acc_w_ok(input int acc_w, input int in_w, input int wt_w, input int n_in);
    return acc_w >= in_w + wt_w + $clog2(n_in);
  endfunction

endpackage

// File: rtl/fc_sat.sv
// Combinational clamp of the accumulator into a signed OUT_W result, flagging any clamp.
// FC_LAYER_ENGINE_RELU_EN: negative sums become 0 and never flag.
module fc_sat #(
  parameter int ACC_W = 52,
  parameter int OUT_W = 38
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic [OUT_W-1:0]        sat_val,
  output logic                    clamped
);

  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};

  always_comb begin
    sat_val = acc[OUT_W-1:0];
    clamped = 1'b0;
    if (acc > MAX_V) begin
      sat_val = MAX_V[OUT_W-1:0];
      clamped = 1'b1;
    end
`ifdef FC_LAYER_ENGINE_RELU_EN
    else if (acc[ACC_W-1]) begin
      sat_val = '0;
    end
`else
    else if (acc < ~MAX_V) begin
      sat_val = ~MAX_V[OUT_W-1:0];
      clamped = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/fc_layer_engine.sv
// Sequential FC layer: one signed MAC per cycle per neuron, bias, saturate (ReLU if FC_LAYER_ENGINE_RELU_EN).
// First result N_IN+2 cycles after LOAD; each result held on out_valid until out_ready, no prefetch.
module fc_layer_engine
  import fc_pkg::*;
#(
  parameter int N_IN  = FC_N_IN,
  parameter int N_OUT = FC_N_OUT,
  parameter int IN_W  = FC_IN_W,
  parameter int WT_W  = FC_WT_W,
  parameter int B_W   = FC_B_W,
  parameter int ACC_W = FC_ACC_W,
  parameter int OUT_W = FC_OUT_W
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic [$clog2(N_IN)-1:0]         in_addr,
  input  logic [IN_W-1:0]                 in_data,
  output logic [$clog2(N_IN*N_OUT)-1:0]   w_addr,
  input  logic [WT_W-1:0]                 w_data,
  output logic [$clog2(N_OUT)-1:0]        b_addr,
  input  logic [B_W-1:0]                  b_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(N_OUT)-1:0]        out_idx,
  output logic [OUT_W-1:0]                out_data,
  output logic                            ovf
);

  localparam int IA = $clog2(N_IN);
  localparam int WA = $clog2(N_IN*N_OUT);
  localparam int NW = $clog2(N_OUT);
  localparam int PW = IN_W + WT_W;
  localparam logic [IA-1:0] K_LAST = IA'(N_IN-1);
  localparam logic [NW-1:0] N_LAST = NW'(N_OUT-1);

  if (!acc_w_ok(ACC_W, IN_W, WT_W, N_IN)) begin : g_acc_w_check
    $error("fc_layer_engine: ACC_W too narrow for IN_W+WT_W+clog2(N_IN)");
  end

  state_t state, state_nxt;
  logic [NW-1:0] n;
  logic [IA-1:0] k;
  logic signed [ACC_W-1:0] acc;
  logic signed [PW-1:0] prod;
  logic signed [ACC_W-1:0] mac_term;
  logic [OUT_W-1:0] sat_val;
  logic sat_clamped;
  logic n_last;

  assign n_last   = (n == N_LAST);
  assign prod     = PW'($signed(in_data)) * PW'($signed(w_data));
  assign mac_term = ACC_W'(prod) + ((k == '0) ? ACC_W'($signed(b_data)) : '0);

  fc_sat #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_sat (
    .acc     (acc),
    .sat_val (sat_val),
    .clamped (sat_clamped)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: state_nxt = MAC;
      MAC:  if (k == K_LAST) state_nxt = SAT;
      SAT:  state_nxt = EMIT;
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = n_last ? FIN : LOAD;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Addresses run one element ahead of k so RAM data lands in the MAC cycle that consumes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n        <= '0;
      k        <= '0;
      acc      <= '0;
      in_addr  <= '0;
      w_addr   <= '0;
      b_addr   <= '0;
      out_idx  <= '0;
      out_data <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          n       <= '0;
          ovf     <= 1'b0;
          in_addr <= '0;
          w_addr  <= '0;
          b_addr  <= '0;
        end
        LOAD, MAC: begin
          if (state == LOAD) begin
            acc <= '0;
            k   <= '0;
          end else begin
            acc <= acc + mac_term;
            if (k != K_LAST) k <= k + IA'(1);
          end
          if (in_addr != K_LAST) begin
            in_addr <= in_addr + IA'(1);
            w_addr  <= w_addr + WA'(1);
          end
        end
        SAT: begin
          out_data <= sat_val;
          out_idx  <= n;
          if (sat_clamped) ovf <= 1'b1;
        end
        EMIT: if (out_ready && !n_last) begin
          n       <= n + NW'(1);
          in_addr <= '0;
          w_addr  <= WA'((int'(n) + 1) * N_IN);
          b_addr  <= n + NW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fc_layer_engine.md
Name: fc_layer_engine

Overview:
- Sequential fully-connected layer engine: one signed MAC per cycle, computing N_OUT neurons over an N_IN-element input vector.
- Reads activations, weights and biases from external synchronous RAMs by address.
- Adds bias, then saturates (optional ReLU) each neuron's result.
- Streams each result out on a valid/ready port. Replaces the single-neuron, single-cycle FC block in the CNN classifier back end.

Parameters:
- N_IN, 3136, input vector length
- N_OUT, 10, number of neurons
- IN_W, 30, activation width (signed)
- WT_W, 9, weight width (signed)
- B_W, 9, bias width (signed)
- ACC_W, 52, accumulator width; elaboration error if < IN_W+WT_W+$clog2(N_IN)
- OUT_W, 38, result width (signed, saturated)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle run request; ignored while busy
- busy  out  1  high from start acceptance until the cycle done pulses (inclusive)
- done  out  1  one-cycle pulse after the last result is accepted
- in_addr  out  $clog2(N_IN)  activation RAM address
- in_data  in  IN_W  activation, valid 1 cycle after in_addr
- w_addr  out  $clog2(N_IN*N_OUT)  weight address = n*N_IN+k
- w_data  in  WT_W  weight, valid 1 cycle after w_addr
- b_addr  out  $clog2(N_OUT)  bias address = n
- b_data  in  B_W  bias, valid 1 cycle after b_addr
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_idx  out  $clog2(N_OUT)  neuron index of out_data
- out_data  out  OUT_W  saturated result
- ovf  out  1  sticky: any result of this run saturated; cleared on start acceptance

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, out_valid, ovf = 0; all addresses, out_idx, out_data = 0; accumulator = 0; neuron counter n = 0; element counter k = 0.
- FSM states: IDLE, LOAD, MAC, SAT, EMIT, FIN.
- IDLE: on start=1 → LOAD. Sets n=0, ovf=0, busy=1.
- LOAD (1 cycle): drive in_addr=0, w_addr=n*N_IN, b_addr=n; acc ← 0; k ← 0 → MAC.
- MAC (N_IN cycles, k=0..N_IN-1): acc ← acc + sext(in_data)*sext(w_data); on k=0 also add sext(b_data).
  - Addresses advance to k+1 each cycle; on the final cycle they hold.
  - After k=N_IN-1 → SAT.
- SAT (1 cycle): clamp acc to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and register into out_data, out_idx=n. Set ovf if clamped. → EMIT.
- EMIT: out_valid=1; out_data and out_idx held stable until out_ready=1.
  - On handshake: out_valid drops next cycle.
  - If n<N_OUT-1: n++ → LOAD; else → FIN.
- FIN (1 cycle): done=1 → IDLE; busy drops the cycle after FIN.
- Latency: out_valid rises N_IN+2 cycles after LOAD entry. Per-neuron minimum is N_IN+3 cycles (out_ready tied high).
- Simultaneous events:
  - out_ready held high with out_valid low: no effect.
  - start in FIN or any busy state: ignored, no queuing.
  - start in the cycle after FIN (IDLE): accepted.
- rst_n asserted mid-run: immediate abort to reset values; no partial result or done is emitted.
- Arithmetic: all signed two's complement. Product width IN_W+WT_W, sign-extended to ACC_W; no wrap is possible given the ACC_W rule.

Optional Feature:
- Macro: FC_LAYER_ENGINE_RELU_EN.
- Defined: SAT stage outputs 0 for negative acc; positive values are clamped to 2^(OUT_W-1)-1 (ovf set if clamped). Negative values never set ovf.
- Undefined: symmetric signed saturation as above.

Decomposition:
- Package fc_pkg holds:
  - the FSM state enum type
  - default width constants IN_W/WT_W/B_W/OUT_W
  - the ACC_W minimum check function
- Sub-module fc_sat (combinational clamp + optional ReLU, outputs value and clamped flag), instantiated by the SAT stage.

Test Plan (N_IN=4, N_OUT=3, IN_W=8, WT_W=4, B_W=4, ACC_W=16, OUT_W=8; RAM models with 1-cycle latency):
- Nominal run: in={1,2,3,4}; weights row0={1,1,1,1}, row1={2,0,-1,1}, row2={-1,-1,-1,-1}; b={0,3,-2}; out_ready=1 → results (0,10),(1,6),(2,-12); done 1 cycle after third handshake; busy falling the cycle after done.
- Saturation: in all 127, weights all 7, b=7 → every out_data=127; ovf=1. Negative mirror (weights all -8) → out_data=-128; ovf=1. A subsequent start clears ovf.
- Backpressure: out_ready=0 for 5 cycles at each EMIT → out_data/out_idx stable; no LOAD until handshake; results identical to nominal.
- Start while busy: pulse start mid-MAC and during FIN → ignored; exactly 3 results and one done.
- Reset mid-run: drop rst_n during neuron 1 MAC → all outputs 0 immediately; after release, a fresh start yields the nominal results.
- With FC_LAYER_ENGINE_RELU_EN: nominal stimulus → (2,0) instead of -12; ovf=0.
